// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage.
//
// Holds one retired-instruction slot captured from MEM. It performs load
// extraction and result selection, drives the register-file write port, and
// exposes the same result as a forwarding source for EX. It also counts
// retired instructions.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stall, flush       freeze the slot / replace the incoming instruction with a bubble
//   mem_*              instruction fields presented by the MEM stage
//   RFWr, A3, WD       register-file write port (RFWr pulses once per instruction)
//   fwd_valid/rd/data  forwarding source, valid for the whole WB residency
//   instret            retired-instruction counter (wraps)
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wdsel,
  input  logic [2:0]  mem_ldtype,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_dmout,
  input  logic [31:0] mem_pc4,
  output logic        RFWr,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [31:0] instret
);

  logic        valid_q, valid_d;
  logic        fired_q, fired_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  wdsel_q, wdsel_d;
  logic [2:0]  ldtype_q, ldtype_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] dmout_q, dmout_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instret_q, instret_d;

  // Next-state: flush beats stall; a flushed slot keeps its stale fields but is invalid.
  always_comb begin
    valid_d    = valid_q;
    fired_d    = fired_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    wdsel_d    = wdsel_q;
    ldtype_d   = ldtype_q;
    alu_d      = alu_q;
    dmout_d    = dmout_q;
    pc4_d      = pc4_q;
    instret_d  = instret_q;

    // Retirement is counted once, on the edge that ends the first WB cycle.
    if (valid_q && !fired_q) begin
      instret_d = instret_q + 32'd1;
    end

    if (flush) begin
      valid_d = 1'b0;
      fired_d = 1'b0;
    end else if (stall) begin
      // Once the instruction has had its write cycle, further stall cycles must not rewrite.
      fired_d = fired_q | valid_q;
    end else begin
      valid_d    = mem_valid;
      fired_d    = 1'b0;
      regwrite_d = mem_regwrite;
      rd_d       = mem_rd;
      wdsel_d    = mem_wdsel;
      ldtype_d   = mem_ldtype;
      alu_d      = mem_alu;
      dmout_d    = mem_dmout;
      pc4_d      = mem_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      fired_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
      wdsel_q    <= 2'd0;
      ldtype_q   <= 3'd0;
      alu_q      <= 32'd0;
      dmout_q    <= 32'd0;
      pc4_q      <= 32'd0;
      instret_q  <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      fired_q    <= fired_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdsel_q    <= wdsel_d;
      ldtype_q   <= ldtype_d;
      alu_q      <= alu_d;
      dmout_q    <= dmout_d;
      pc4_q      <= pc4_d;
      instret_q  <= instret_d;
    end
  end

  // Little-endian load extraction; misaligned offsets simply drop the low address bits.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  always_comb begin
    unique case (alu_q[1:0])
      2'd0: ld_byte = dmout_q[7:0];
      2'd1: ld_byte = dmout_q[15:8];
      2'd2: ld_byte = dmout_q[23:16];
      2'd3: ld_byte = dmout_q[31:24];
    endcase
    ld_half = alu_q[1] ? dmout_q[31:16] : dmout_q[15:0];
    case (ldtype_q)
      3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_val = {16'd0, ld_half};
      3'd3:    ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_val = {24'd0, ld_byte};
      default: ld_val = dmout_q;
    endcase
  end

  logic [31:0] wd_val;
  logic        writes_reg;

  always_comb begin
    case (wdsel_q)
      2'd1:    wd_val = ld_val;
      2'd2:    wd_val = pc4_q;
      default: wd_val = alu_q;
    endcase
    writes_reg = valid_q & regwrite_q & (rd_q != 5'd0);
  end

  assign RFWr      = writes_reg & ~fired_q;
  assign A3        = rd_q;
  assign WD        = wd_val;
  assign fwd_valid = writes_reg;
  assign fwd_rd    = rd_q;
  assign fwd_data  = wd_val;
  assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed literal checks followed by randomized traffic,
// checked every cycle against a behavioural model of the WB slot.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_valid, mem_regwrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wdsel;
  logic [2:0]  mem_ldtype;
  logic [31:0] mem_alu, mem_dmout, mem_pc4;
  logic        RFWr, fwd_valid;
  logic [4:0]  A3, fwd_rd;
  logic [31:0] WD, fwd_data, instret;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .mem_valid   (mem_valid),
    .mem_regwrite(mem_regwrite),
    .mem_rd      (mem_rd),
    .mem_wdsel   (mem_wdsel),
    .mem_ldtype  (mem_ldtype),
    .mem_alu     (mem_alu),
    .mem_dmout   (mem_dmout),
    .mem_pc4     (mem_pc4),
    .RFWr        (RFWr),
    .A3          (A3),
    .WD          (WD),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .instret     (instret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_started = 1'b0;
  logic        m_clean;
  logic        m_valid, m_fired, m_rw;
  logic [4:0]  m_rd;
  logic [1:0]  m_wdsel;
  logic [2:0]  m_ldtype;
  logic [31:0] m_alu, m_dm, m_pc4, m_instret;

  function automatic logic [31:0] model_load(input logic [31:0] dm, input logic [31:0] a,
                                             input logic [2:0] t);
    int unsigned hoff = (a % 4) / 2 * 16;
    int unsigned boff = (a % 4) * 8;
    int unsigned h = (dm >> hoff) & 32'hFFFF;
    int unsigned b = (dm >> boff) & 32'hFF;
    case (t)
      3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      default: return dm;
    endcase
  endfunction

  function automatic logic [31:0] model_wd();
    if (m_wdsel == 2'd1) return model_load(m_dm, m_alu, m_ldtype);
    if (m_wdsel == 2'd2) return m_pc4;
    return m_alu;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_started <= 1'b1;
      m_clean   <= 1'b1;
      m_valid   <= 1'b0;
      m_fired   <= 1'b0;
      m_rw      <= 1'b0;
      m_rd      <= '0;
      m_wdsel   <= '0;
      m_ldtype  <= '0;
      m_alu     <= '0;
      m_dm      <= '0;
      m_pc4     <= '0;
      m_instret <= '0;
    end else begin
      if (m_valid && !m_fired) m_instret <= m_instret + 1;
      if (flush) begin
        m_valid <= 1'b0;
        m_fired <= 1'b0;
      end else if (stall) begin
        if (m_valid) m_fired <= 1'b1;
      end else begin
        m_clean  <= 1'b0;
        m_valid  <= mem_valid;
        m_fired  <= 1'b0;
        m_rw     <= mem_regwrite;
        m_rd     <= mem_rd;
        m_wdsel  <= mem_wdsel;
        m_ldtype <= mem_ldtype;
        m_alu    <= mem_alu;
        m_dm     <= mem_dmout;
        m_pc4    <= mem_pc4;
      end
    end
  end

  // Compare process: outputs depend only on registered state, so mid-cycle sampling is safe.
  always @(negedge clk) begin
    if (m_started) begin
      logic writes;
      writes = m_valid && m_rw && (m_rd != 0);
      chk("model_RFWr", {31'd0, RFWr}, {31'd0, writes && !m_fired});
      chk("model_fwd_valid", {31'd0, fwd_valid}, {31'd0, writes});
      chk("model_instret", instret, m_instret);
      // Fields of an invalid slot are only defined while still at their reset value.
      if (m_valid || m_clean) begin
        chk("model_A3", {27'd0, A3}, {27'd0, m_rd});
        chk("model_fwd_rd", {27'd0, fwd_rd}, {27'd0, m_rd});
        chk("model_WD", WD, model_wd());
        chk("model_fwd_data", fwd_data, model_wd());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] ws, input logic [2:0] lt, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [31:0] pc4);
    mem_valid    = v;
    mem_regwrite = rw;
    mem_rd       = rd;
    mem_wdsel    = ws;
    mem_ldtype   = lt;
    mem_alu      = alu;
    mem_dmout    = dm;
    mem_pc4      = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_RFWr"}, {31'd0, RFWr}, 32'd0);
    chk({tag, "_A3"}, {27'd0, A3}, 32'd0);
    chk({tag, "_WD"}, WD, 32'd0);
    chk({tag, "_fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
    chk({tag, "_fwd_rd"}, {27'd0, fwd_rd}, 32'd0);
    chk({tag, "_fwd_data"}, fwd_data, 32'd0);
    chk({tag, "_instret"}, instret, 32'd0);
  endtask

  localparam logic [31:0] Dm = 32'h80FF7F01;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // ALU write, then a bubble to retire it
    drive(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h12345678, 32'd0, 32'd0);
    tick();
    chk("alu_RFWr", {31'd0, RFWr}, 32'd1);
    chk("alu_A3", {27'd0, A3}, 32'd5);
    chk("alu_WD", WD, 32'h12345678);
    chk("alu_instret_before", instret, 32'd0);
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chk("alu_instret_after", instret, 32'd1);

    // Loads from 0x80FF7F01
    drive(1'b1, 1'b1, 5'd6, 2'd1, 3'd3, 32'h3, Dm, 32'd0); tick();
    chk("lb_off3", WD, 32'hFFFFFF80);
    drive(1'b1, 1'b1, 5'd6, 2'd1, 3'd4, 32'h3, Dm, 32'd0); tick();
    chk("lbu_off3", WD, 32'h00000080);
    drive(1'b1, 1'b1, 5'd6, 2'd1, 3'd1, 32'h2, Dm, 32'd0); tick();
    chk("lh_off2", WD, 32'hFFFF80FF);
    drive(1'b1, 1'b1, 5'd6, 2'd1, 3'd2, 32'h0, Dm, 32'd0); tick();
    chk("lhu_off0", WD, 32'h00007F01);
    drive(1'b1, 1'b1, 5'd6, 2'd1, 3'd0, 32'h3, Dm, 32'd0); tick();
    chk("lw_misaligned", WD, 32'h80FF7F01);

    // jal
    drive(1'b1, 1'b1, 5'd31, 2'd2, 3'd0, 32'hDEAD, 32'd0, 32'h00003004); tick();
    chk("jal_RFWr", {31'd0, RFWr}, 32'd1);
    chk("jal_A3", {27'd0, A3}, 32'd31);
    chk("jal_WD", WD, 32'h00003004);

    // rd = 0 still retires
    drive(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'h55, 32'd0, 32'd0); tick();
    chk("rd0_RFWr", {31'd0, RFWr}, 32'd0);
    chk("rd0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0); tick();
    chk("rd0_instret", instret, 32'd8);

    // Stall held 3 cycles after load: single write pulse, forwarding throughout
    drive(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 32'hCAFE0001, 32'd0, 32'd0); tick();
    chk("stall_c0_RFWr", {31'd0, RFWr}, 32'd1);
    chk("stall_c0_fwd", {31'd0, fwd_valid}, 32'd1);
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 32'h1111, 32'd0, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("stall_c%0d_RFWr", i), {31'd0, RFWr}, 32'd0);
      chk($sformatf("stall_c%0d_fwd", i), {31'd0, fwd_valid}, 32'd1);
      chk($sformatf("stall_c%0d_data", i), fwd_data, 32'hCAFE0001);
      chk($sformatf("stall_c%0d_instret", i), instret, 32'd9);
    end
    stall = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0); tick();
    chk("stall_end_instret", instret, 32'd9);

    // Flush beats stall
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'h77, 32'd0, 32'd0); tick();
    chk("flush_RFWr", {31'd0, RFWr}, 32'd0);
    chk("flush_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("flush_instret", instret, 32'd9);

    // Reset beats flush/stall
    rst = 1'b1; tick();
    chk_all_zero("rst_over");
    rst = 1'b0; stall = 1'b0; flush = 1'b0;

    // Randomized traffic, checked by the compare process each cycle
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), rd,
            2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
    end

    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have no parameters; all widths are fixed (32-bit datapath, 5-bit register index).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: stall  in  1  pipeline freeze; flush  in  1  discard incoming MEM instruction.
REQ-005 SHALL have ports: mem_valid  in  1;  mem_regwrite  in  1;  mem_rd  in  5  destination register.
REQ-006 SHALL have ports: mem_wdsel  in  2  (0 ALU, 1 load, 2 PC+4, 3 reserved->ALU);  mem_ldtype  in  3  (0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, others->LW).
REQ-007 SHALL have ports: mem_alu  in  32  ALU result/effective address;  mem_dmout  in  32  raw data-memory word;  mem_pc4  in  32.
REQ-008 SHALL have ports: RFWr  out  1;  A3  out  5;  WD  out  32  register-file write port.
REQ-009 SHALL have ports: fwd_valid  out  1;  fwd_rd  out  5;  fwd_data  out  32  forwarding source for EX.
REQ-010 SHALL have ports: instret  out  32  retired-instruction count.

Function
REQ-011 SHALL hold one WB register set: valid, regwrite, rd, wdsel, ldtype, alu, dmout, pc4, plus a fired bit.
REQ-012 On an edge with rst=0 and flush=1: valid<=0, fired<=0 (bubble); flush overrides stall.
REQ-013 On an edge with rst=0, flush=0, stall=1: all WB fields hold; fired<=1 if valid.
REQ-014 On an edge with rst=0, flush=0, stall=0: all fields load from mem_*; fired<=0.
REQ-015 Load extraction, little-endian, byte offset = alu[1:0]: LW whole word; LH/LHU halfword at bit 16*alu[1]; LB/LBU byte at bit 8*alu[1:0]; LH/LB sign-extend, LHU/LBU zero-extend.
REQ-016 Misaligned halfword (alu[0]=1) SHALL ignore alu[0]; misaligned LW SHALL ignore alu[1:0]; no fault raised.
REQ-017 WD SHALL be combinational from WB register: wdsel 0/3 -> alu, 1 -> extracted load, 2 -> pc4.
REQ-018 A3 SHALL equal WB rd; RFWr = valid & regwrite & (rd!=0) & ~fired.
REQ-019 Each instruction SHALL assert RFWr for exactly one cycle, the first cycle it occupies WB, regardless of stall length.
REQ-020 fwd_valid = valid & regwrite & (rd!=0), independent of fired; fwd_rd = rd; fwd_data = WD.
REQ-021 Latency: MEM inputs sampled at edge k -> RFWr/WD valid between edges k and k+1 -> register file updated at edge k+1.
REQ-022 instret SHALL increment by 1 on each edge where valid & ~fired & ~rst, whether or not regwrite is set; wraps 0xFFFFFFFF->0.
REQ-023 Writes to rd=0 SHALL never assert RFWr or fwd_valid but SHALL count in instret.

Reset
REQ-024 On an edge with rst=1: valid, fired, regwrite, rd, wdsel, ldtype, alu, dmout, pc4 <=0; instret<=0; rst overrides flush and stall.
REQ-025 During and after reset until first load: RFWr=0, A3=0, WD=0, fwd_valid=0, fwd_rd=0, fwd_data=0, instret=0.
REQ-026 Reset asserted while an instruction sits in WB SHALL suppress its write from the following cycle onward; instret not incremented on the reset edge.

Verification
REQ-027 ALU write: valid=1, regwrite=1, rd=5, wdsel=0, alu=0x12345678 -> next cycle RFWr=1, A3=5, WD=0x12345678; instret 0->1 on following edge.
REQ-028 Loads: dmout=0x80FF7F01, wdsel=1: LB alu[1:0]=3 -> WD=0xFFFFFF80; LBU off 3 -> 0x00000080; LH off 2 -> 0xFFFF80FF; LHU off 0 -> 0x00007F01; LW -> 0x80FF7F01.
REQ-029 jal: wdsel=2, rd=31, pc4=0x00003004 -> RFWr=1, A3=31, WD=0x00003004.
REQ-030 rd=0, regwrite=1 -> RFWr=0, fwd_valid=0, instret increments.
REQ-031 Instruction loaded then stall held 3 cycles -> RFWr=1 only first cycle, fwd_valid=1 all 4 cycles, instret +1 total.
REQ-032 flush=1 with stall=1 and mem_valid=1 -> next cycle RFWr=0, fwd_valid=0; rst=1 with flush/stall -> all outputs 0, instret=0.
